alu_muldiv_seq: RTL and testbench

Multi-cycle multiply/divide sequencer for the EX stage of the pipelined RISC core. It accepts R-type MULT/MULTU/DIV/DIVU requests, identified by `aluop == 2'b10` and the instruction funct field. It runs a 32-iteration shift-add or restoring-divide datapath, stalls the pipeline while busy, and writes the 64-bit result to architectural HI/LO registers. Single-cycle ALU ops bypass this block and go through the existing ALU control path.

---
 rtl/alu_muldiv_seq.sv | 149 ++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_seq
// Description : Multi-cycle MULT/MULTU/DIV/DIVU sequencer writing HI/LO,
//               stalling the EX stage while an operation is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int          c_cnt_w   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [1:0]  c_st_idle = 2'd0;
    localparam logic [1:0]  c_st_run  = 2'd1;
    localparam logic [1:0]  c_st_fix  = 2'd2;
    localparam logic [1:0]  c_st_done = 2'd3;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    logic [1:0]         r_state, w_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_is_div, r_neg_lo, r_neg_hi, r_dz;
    logic [WIDTH-1:0]   r_b, r_hi, r_lo;
    logic [2*WIDTH-1:0] r_acc;

    logic               w_accept, w_is_div, w_divzero, w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [WIDTH:0]     w_sum, w_trial;
    logic [2*WIDTH-1:0] w_step, w_prod;
    logic [WIDTH-1:0]   w_res_hi, w_res_lo;

    // funct 0110xx selects the four mul/div ops; bit1 = divide, bit0 = unsigned
    assign w_accept  = start & (aluop == 2'b10) & (funct[5:2] == 4'b0110)
                       & (r_state == c_st_idle);
    assign w_is_div  = funct[1];
    assign w_divzero = w_is_div & (op_b == '0);
    assign w_a_neg   = ~funct[0] & op_a[WIDTH-1];
    assign w_b_neg   = ~funct[0] & op_b[WIDTH-1];
    assign w_a_mag   = w_a_neg ? (~op_a + 1'b1) : op_a;
    assign w_b_mag   = w_b_neg ? (~op_b + 1'b1) : op_b;

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, quotient}
    assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
    assign w_step  = !r_is_div ? {w_sum, r_acc[WIDTH-1:1]} :
                     w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0} :
                                      {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_prod = r_neg_lo ? (~r_acc + 1'b1) : r_acc;

    always_comb begin
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            w_res_lo = r_neg_lo ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
            w_res_hi = r_neg_hi ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1)
                                : r_acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= c_st_idle;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: if (w_accept) w_next = w_divzero ? c_st_fix : c_st_run;
            c_st_run:  if (r_cnt == c_last) w_next = c_st_fix;
            c_st_fix:  w_next = c_st_done;
            default:   w_next = c_st_idle;
        endcase
    end

    always_comb begin
        busy  = (r_state != c_st_idle);
        stall = w_accept | (r_state == c_st_run) | (r_state == c_st_fix);
        done  = (r_state == c_st_done);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_dz     <= 1'b0;
            r_b      <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                c_st_idle: if (w_accept) begin
                    r_cnt    <= '0;
                    r_is_div <= w_is_div;
                    r_dz     <= w_divzero;
                    if (w_divzero) begin
                        // Preloaded result passes through FIX untouched
                        r_neg_lo <= 1'b0;
                        r_neg_hi <= 1'b0;
                        r_b      <= '0;
                        r_acc    <= {op_a, {WIDTH{1'b1}}};
                    end else if (w_is_div) begin
                        r_neg_lo <= w_a_neg ^ w_b_neg;
                        r_neg_hi <= w_a_neg;
                        r_b      <= w_b_mag;
                        r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                    end else begin
                        r_neg_lo <= w_a_neg ^ w_b_neg;
                        r_neg_hi <= 1'b0;
                        r_b      <= w_a_mag;
                        r_acc    <= {{WIDTH{1'b0}}, w_b_mag};
                    end
                end
                c_st_run: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_acc <= w_step;
                end
                c_st_fix: begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
                default: ;
            endcase
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_zero = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_muldiv_seq
// Description : Directed + random bench for alu_muldiv_seq against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] op_a, op_b;
    logic        stall, busy, done, div_zero;
    logic [31:0] hi, lo;

    int n_assert = 0;
    int n_fail   = 0;
    int op_idx   = 0;

    alu_muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .aluop(aluop), .funct(funct),
        .op_a(op_a), .op_b(op_b), .stall(stall), .busy(busy), .done(done),
        .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output logic dz);
        longint          sa, sb, p, q, r;
        longint unsigned up;
        sa = $signed(a);
        sb = $signed(b);
        dz = 1'b0;
        h  = '0;
        l  = '0;
        case (f)
            6'h18: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            6'h19: begin up = 64'(a) * 64'(b); h = up[63:32]; l = up[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    dz = 1'b1; h = a; l = 32'hFFFF_FFFF;
                end else if (f == 6'h1a) begin
                    q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0];
                end else begin
                    h = a % b; l = a / b;
                end
            end
        endcase
    endfunction

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit inject);
        logic [31:0] eh, el;
        logic        edz;
        int          lat, nst, lat_exp;
        bit          seen;
        model(f, a, b, eh, el, edz);
        lat_exp = edz ? 2 : 34;
        op_idx++;
        @(negedge clk);
        start = 1'b1; aluop = 2'b10; funct = f; op_a = a; op_b = b;
        #1 check($sformatf("op%0d_stall_accept", op_idx), stall, 1);
        lat = 0; nst = 0; seen = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (inject && k == 5) begin
                start = 1'b1; aluop = 2'b10; funct = f ^ 6'h01;
                op_a = $urandom; op_b = $urandom;
            end else begin
                start = 1'b0; aluop = 2'($urandom); funct = 6'($urandom);
                op_a = $urandom; op_b = $urandom;
            end
            if (done) begin lat = k; seen = 1; break; end
            if (stall) nst++;
        end
        start = 1'b0;
        check($sformatf("op%0d_done_seen", op_idx), seen, 1);
        check($sformatf("op%0d_latency", op_idx), lat, lat_exp);
        check($sformatf("op%0d_stall_cycles", op_idx), nst, lat_exp - 1);
        check($sformatf("op%0d_hi", op_idx), hi, eh);
        check($sformatf("op%0d_lo", op_idx), lo, el);
        check($sformatf("op%0d_div_zero", op_idx), div_zero, edz);
        check($sformatf("op%0d_busy_done", op_idx), busy, 1);
        check($sformatf("op%0d_stall_done", op_idx), stall, 0);
        @(negedge clk);
        check($sformatf("op%0d_done_clear", op_idx), done, 0);
        check($sformatf("op%0d_idle", op_idx), busy, 0);
        check($sformatf("op%0d_hold", op_idx), {hi, lo}, {eh, el});
    endtask

    initial begin
        logic [31:0] sv_hi, sv_lo, ra, rb;
        logic [5:0]  rf;
        int          n_done;
        rst_n = 1'b0; start = 1'b0; aluop = 2'b00; funct = '0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_div_zero", div_zero, 0);
        check("rst_stall", stall, 0);
        rst_n = 1'b1;

        run_op(6'h19, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_op(6'h18, -32'sd3, 32'sd5, 1'b1);
        run_op(6'h1a, -32'sd7, 32'sd2, 1'b0);
        run_op(6'h1a, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op(6'h1b, 32'd100, 32'd0, 1'b0);
        run_op(6'h19, 32'd1, 32'd1, 1'b0);
        run_op(6'h1a, 32'd0, 32'd0, 1'b0);
        run_op(6'h1b, 32'hFFFF_FFFF, 32'd7, 1'b0);

        // Requests that must be ignored while idle
        sv_hi = hi; sv_lo = lo;
        @(negedge clk);
        start = 1'b1; aluop = 2'b00; funct = 6'h18; op_a = 32'd5; op_b = 32'd7;
        #1 check("ign_aluop_stall", stall, 0);
        @(negedge clk);
        check("ign_aluop_busy", busy, 0);
        aluop = 2'b10; funct = 6'h20;
        #1 check("ign_funct_stall", stall, 0);
        @(negedge clk);
        start = 1'b0;
        check("ign_funct_busy", busy, 0);
        check("ign_hold", {hi, lo}, {sv_hi, sv_lo});

        for (int i = 0; i < 16; i++) begin
            rf = 6'h18 + 6'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'(($urandom_range(0, 1) == 0) ? 1 : -1);
            run_op(rf, ra, rb, ($urandom_range(0, 3) == 0) && !(rf[1] && rb == 0));
        end

        // Reset during RUN iteration 10 aborts without a done pulse
        @(negedge clk);
        start = 1'b1; aluop = 2'b10; funct = 6'h19; op_a = 32'h1234_5677; op_b = 32'h89AB_CDEF;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_done", done, 0);
        n_done = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        check("abort_still_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
